sdram_read: RTL and testbench



---
 rtl/sdram_pkg.sv | 42 ++++
 rtl/sdram_read.sv | 143 ++++++++++++++
 tb/tb_sdram_read.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings,
// default timing, read-path state encoding and helpers.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_BSTOP  = 4'b0110;
  localparam logic [3:0] CMD_PRE    = 4'b0010;

  localparam int TRCD_DEF = 2;
  localparam int TRP_DEF  = 2;
  localparam int CL_DEF   = 3;

  localparam logic [1:0]  BA_IDLE   = 2'b11;
  localparam logic [12:0] ADDR_IDLE = 13'h1fff;
  localparam logic [12:0] ADDR_A10  = 13'h0400;

  localparam logic [9:0] BURST_MIN = 10'd4;
  localparam logic [9:0] BURST_MAX = 10'd512;

  typedef enum logic [8:0] {
    RD_IDLE   = 9'b000000001,
    RD_ACTIVE = 9'b000000010,
    RD_TRCD   = 9'b000000100,
    RD_READ   = 9'b000001000,
    RD_CL     = 9'b000010000,
    RD_DATA   = 9'b000100000,
    RD_PRE    = 9'b001000000,
    RD_TRP    = 9'b010000000,
    RD_END    = 9'b100000000
  } rd_state_e;

  function automatic logic [9:0] clamp_burst(
    input logic [9:0] len
  );
    if (len < BURST_MIN)      return BURST_MIN;
    else if (len > BURST_MAX) return BURST_MAX;
    else                      return len;
  endfunction

endpackage

// File: rtl/sdram_read.sv
// SDRAM read engine: ACTIVE, READ, burst capture,
// BURST_STOP and PRECHARGE for one full-page burst.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int TRCD_CLK = TRCD_DEF,
  parameter int TRP_CLK  = TRP_DEF,
  parameter int CAS_LAT  = CL_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr_in,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_data_in,
  output logic        rd_end,
  output logic [3:0]  rd_cmd,
  output logic [1:0]  rd_ba,
  output logic [12:0] rd_addr,
  output logic        rd_ack,
  output logic [15:0] rd_sdram_data
);

  localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
  localparam logic [9:0] CL_LAST   = 10'(CAS_LAT - 2);
  localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 1);
  localparam logic [9:0] CL_W      = 10'(CAS_LAT);

  rd_state_e   r_state;
  rd_state_e   w_next;
  logic [9:0]  r_cnt;
  logic [1:0]  r_ba;
  logic [12:0] r_row;
  logic [8:0]  r_col;
  logic [9:0]  r_len;
  logic        r_ack;
  logic [15:0] r_data;

  logic [3:0]  w_cmd;
  logic [1:0]  w_ba;
  logic [12:0] w_addr;
  logic        w_end;
  logic        w_grant;
  logic [9:0]  w_stop_cnt;
  logic [9:0]  w_last_cnt;

  assign w_grant    = init_end & rd_en;
  assign w_stop_cnt = r_len - CL_W;
  assign w_last_cnt = r_len - 10'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= RD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 10'd1;
    end
  end

  // Request fields are frozen at grant for the whole burst.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ba  <= '0;
      r_row <= '0;
      r_col <= '0;
      r_len <= BURST_MIN;
    end else if (r_state == RD_IDLE && w_grant) begin
      r_ba  <= rd_addr_in[23:22];
      r_row <= rd_addr_in[21:9];
      r_col <= rd_addr_in[8:0];
      r_len <= clamp_burst(rd_burst_len);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ack  <= 1'b0;
      r_data <= '0;
    end else begin
      r_ack  <= (r_state == RD_DATA);
      r_data <= rd_data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    w_cmd  = CMD_NOP;
    w_ba   = BA_IDLE;
    w_addr = ADDR_IDLE;
    w_end  = 1'b0;
    unique case (r_state)
      RD_IDLE: begin
        if (w_grant) w_next = RD_ACTIVE;
      end
      RD_ACTIVE: begin
        w_cmd  = CMD_ACTIVE;
        w_ba   = r_ba;
        w_addr = r_row;
        w_next = RD_TRCD;
      end
      RD_TRCD: begin
        if (r_cnt == TRCD_LAST) w_next = RD_READ;
      end
      RD_READ: begin
        w_cmd  = CMD_READ;
        w_ba   = r_ba;
        w_addr = {4'b0000, r_col};
        w_next = RD_CL;
      end
      RD_CL: begin
        if (r_cnt == CL_LAST) w_next = RD_DATA;
      end
      RD_DATA: begin
        if (r_cnt == w_stop_cnt) w_cmd = CMD_BSTOP;
        if (r_cnt == w_last_cnt) w_next = RD_PRE;
      end
      RD_PRE: begin
        w_cmd  = CMD_PRE;
        w_ba   = r_ba;
        w_addr = ADDR_A10;
        w_next = RD_TRP;
      end
      RD_TRP: begin
        if (r_cnt == TRP_LAST) w_next = RD_END;
      end
      RD_END: begin
        w_end  = 1'b1;
        w_next = RD_IDLE;
      end
      default: w_next = RD_IDLE;
    endcase
  end

  assign rd_cmd        = w_cmd;
  assign rd_ba         = w_ba;
  assign rd_addr       = w_addr;
  assign rd_end        = w_end;
  assign rd_ack        = r_ack;
  assign rd_sdram_data = r_data;

endmodule

// File: tb/tb_sdram_read.sv
// Directed and randomized bursts against a timeline model
// derived from the read-protocol rules.
module tb_sdram_read;

  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int CL   = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_end;
  logic        rd_en;
  logic [23:0] rd_addr_in;
  logic [9:0]  rd_burst_len;
  logic [15:0] rd_data_in;
  logic        rd_end;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_sdram_data;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_read #(
    .TRCD_CLK(TRCD),
    .TRP_CLK (TRP),
    .CAS_LAT (CL)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .init_end     (init_end),
    .rd_en        (rd_en),
    .rd_addr_in   (rd_addr_in),
    .rd_burst_len (rd_burst_len),
    .rd_data_in   (rd_data_in),
    .rd_end       (rd_end),
    .rd_cmd       (rd_cmd),
    .rd_ba        (rd_ba),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_sdram_data(rd_sdram_data)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_len(input int n);
    if (n < 4) return 4;
    if (n > 512) return 512;
    return n;
  endfunction

  task automatic run_burst(input logic [23:0] a, input int n,
                           input int drop_at, input logic [15:0] base);
    int lc, t_act, t_rd, t_stop, t_pre, t_end;
    int n_end, n_ack, n_cmd, first_ack, last_ack;
    int bad_data, bad_idle;
    int act_ba, act_row, rd_ba_o, rd_col_o, pre_ba, pre_addr;
    int e_rd;
    lc = ref_len(n);
    t_act = -1; t_rd = -1; t_stop = -1; t_pre = -1; t_end = -1;
    n_end = 0; n_ack = 0; n_cmd = 0; first_ack = -1; last_ack = -1;
    bad_data = 0; bad_idle = 0;
    act_ba = -1; act_row = -1; rd_ba_o = -1; rd_col_o = -1;
    pre_ba = -1; pre_addr = -1;
    @(negedge sys_clk);
    rd_addr_in   = a;
    rd_burst_len = 10'(n);
    rd_en        = 1'b1;
    for (int k = 1; k <= lc + 40; k++) begin
      @(negedge sys_clk);
      if (rd_cmd != 4'b0111) n_cmd++;
      case (rd_cmd)
        4'b0011: if (t_act < 0) begin
          t_act = k; act_ba = int'(rd_ba); act_row = int'(rd_addr);
        end
        4'b0101: if (t_rd < 0) begin
          t_rd = k; rd_ba_o = int'(rd_ba); rd_col_o = int'(rd_addr);
        end
        4'b0110: if (t_stop < 0) t_stop = k;
        4'b0010: if (t_pre < 0) begin
          t_pre = k; pre_ba = int'(rd_ba); pre_addr = int'(rd_addr);
        end
        4'b0111: if (rd_ba !== 2'b11 || rd_addr !== 13'h1fff) bad_idle++;
        default: ;
      endcase
      if (rd_ack) begin
        if (first_ack < 0) first_ack = k;
        last_ack = k;
        if (rd_sdram_data !== base + 16'(n_ack)) bad_data++;
        n_ack++;
      end
      if (rd_end) begin
        n_end++;
        if (t_end < 0) t_end = k;
        rd_en = 1'b0;
      end
      if (k == drop_at) rd_en = 1'b0;
      if (t_rd >= 0 && k >= t_rd + CL && k < t_rd + CL + lc)
        rd_data_in = base + 16'(k - t_rd - CL);
      else
        rd_data_in = 16'($urandom);
      if (t_end >= 0 && k >= t_end + 3) break;
    end
    rd_en = 1'b0;
    e_rd = TRCD + 2;
    chk("act_cycle", t_act, 1);
    chk("act_ba", act_ba, int'(a[23:22]));
    chk("act_row", act_row, int'(a[21:9]));
    chk("read_cycle", t_rd, e_rd);
    chk("read_ba", rd_ba_o, int'(a[23:22]));
    chk("read_col", rd_col_o, int'(a[8:0]));
    chk("stop_cycle", t_stop, e_rd + lc);
    chk("pre_cycle", t_pre, e_rd + CL + lc);
    chk("pre_ba", pre_ba, int'(a[23:22]));
    chk("pre_addr", pre_addr, 'h400);
    chk("end_cycle", t_end, TRCD + CL + lc + TRP + 3);
    chk("end_count", n_end, 1);
    chk("cmd_count", n_cmd, 4);
    chk("ack_count", n_ack, lc);
    chk("ack_first", first_ack, e_rd + CL + 1);
    chk("ack_contig", last_ack - first_ack + 1, lc);
    chk("data_order", bad_data, 0);
    chk("idle_bus", bad_idle, 0);
  endtask

  initial begin
    int cnt_cmd, cnt_end, seen;
    sys_rst_n    = 1'b0;
    init_end     = 1'b1;
    rd_en        = 1'b0;
    rd_addr_in   = '0;
    rd_burst_len = '0;
    rd_data_in   = '0;
    #1;
    chk("rst_cmd", int'(rd_cmd), 'b0111);
    chk("rst_ba", int'(rd_ba), 3);
    chk("rst_addr", int'(rd_addr), 'h1fff);
    chk("rst_ack", int'(rd_ack), 0);
    chk("rst_end", int'(rd_end), 0);
    chk("rst_data", int'(rd_sdram_data), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    run_burst(24'h40_0A05, 8, 0, 16'h1000);
    run_burst(24'h81_2345, 0, 0, 16'h2000);
    run_burst(24'hC0_01FC, 16, 0, 16'h3000);
    run_burst(24'h12_3456, 10, 2, 16'h4000);
    run_burst(24'h3F_FFFF, 1023, 0, 16'h5000);

    for (int i = 0; i < 6; i++)
      run_burst(24'($urandom), $urandom_range(0, 40), 0, 16'($urandom));

    @(negedge sys_clk);
    rd_addr_in   = 24'h55_5155;
    rd_burst_len = 10'd20;
    rd_en        = 1'b1;
    seen = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      @(negedge sys_clk);
      rd_data_in = 16'($urandom);
      if (rd_ack) seen = 1;
    end
    chk("rst_reach_data", seen, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_cmd", int'(rd_cmd), 'b0111);
    chk("midrst_ba", int'(rd_ba), 3);
    chk("midrst_addr", int'(rd_addr), 'h1fff);
    chk("midrst_ack", int'(rd_ack), 0);
    rd_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_burst(24'h9A_BCDE, 6, 0, 16'h6000);

    @(negedge sys_clk);
    init_end = 1'b0;
    rd_en    = 1'b1;
    cnt_cmd  = 0;
    cnt_end  = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      if (rd_cmd !== 4'b0111) cnt_cmd++;
      if (rd_end) cnt_end++;
    end
    chk("noinit_cmds", cnt_cmd, 0);
    chk("noinit_end", cnt_end, 0);
    rd_en    = 1'b0;
    init_end = 1'b1;
    run_burst(24'h01_0003, 5, 0, 16'h7000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
